// File: rtl/fetch_pc_unit_pkg.sv
// Shared pipeline definitions for the fetch stage: word width, jump-op
// encodings, the NOP constant, the IF/ID record and the branch-target helper.
package fetch_pc_unit_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    JOP_SEQ = 2'b00,
    JOP_BR  = 2'b01,
    JOP_JR  = 2'b10,
    JOP_J   = 2'b11
  } jump_op_e;

  localparam word_t NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    word_t instr;
    word_t pc4;
    logic  valid;
  } ifid_t;

  // PC-relative branch: word offset sign-extended and scaled to bytes.
  function automatic word_t branch_target(input word_t pc4, input logic [15:0] imm);
    return pc4 + {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_pc_unit_next_pc_sel.sv
// Combinational next-PC selection: sequential, branch, register jump and
// direct jump targets, plus the register-jump misalignment flag.
module next_pc_sel
  import fetch_pc_unit_pkg::*;
(
  input  jump_op_e    jop,
  input  word_t       pc,
  input  word_t       ifid_pc4,
  input  logic [25:0] instr_idx,
  input  word_t       rs_data,
  output word_t       next_pc,
  output word_t       pc_plus4,
  output logic        misalign
);

  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    next_pc  = pc_plus4;
    misalign = 1'b0;
    case (jop)
      JOP_BR: next_pc = branch_target(ifid_pc4, instr_idx[15:0]);
      JOP_JR: begin
        next_pc  = {rs_data[31:2], 2'b00};
        misalign = |rs_data[1:0];
      end
      JOP_J:  next_pc = {ifid_pc4[31:28], instr_idx, 2'b00};
      default: ;
    endcase
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: PC register, IF/ID register, redirect/flush with
// stall priority, and a wrapping redirect counter.
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter word_t RESET_PC = 32'h0000_0000,
  parameter int    CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic [1:0]       jump_op,
  input  logic [31:0]      rs_data,
  input  logic [31:0]      imem_instr,
  output logic [31:0]      pc_out,
  output logic [31:0]      ifid_instr,
  output logic [31:0]      ifid_pc4,
  output logic             ifid_valid,
  output logic             redirect,
  output logic             misalign,
  output logic [CNT_W-1:0] redirect_count
);

  word_t            pc_q;
  ifid_t            ifid_q;
  logic             redirect_q;
  logic             misalign_q;
  logic [CNT_W-1:0] count_q;

  jump_op_e qual_jop;
  word_t    next_pc;
  word_t    pc_plus4;
  logic     sel_misalign;
  logic     take;

  // A flushed (invalid) slot carries no real control transfer.
  assign qual_jop = ifid_valid ? jump_op_e'(jump_op) : JOP_SEQ;
  assign take     = (qual_jop != JOP_SEQ);

  next_pc_sel u_next_pc_sel (
    .jop       (qual_jop),
    .pc        (pc_q),
    .ifid_pc4  (ifid_q.pc4),
    .instr_idx (ifid_q.instr[25:0]),
    .rs_data   (rs_data),
    .next_pc   (next_pc),
    .pc_plus4  (pc_plus4),
    .misalign  (sel_misalign)
  );

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      pc_q       <= RESET_PC;
      ifid_q     <= '{instr: NOP_INSTR, pc4: '0, valid: 1'b0};
      redirect_q <= 1'b0;
      misalign_q <= 1'b0;
      count_q    <= '0;
    end else if (stall) begin
      redirect_q <= 1'b0;
    end else begin
      pc_q       <= next_pc;
      redirect_q <= take;
      misalign_q <= sel_misalign;
      if (take) begin
        ifid_q  <= '{instr: NOP_INSTR, pc4: '0, valid: 1'b0};
        count_q <= count_q + CNT_W'(1);
      end else begin
        ifid_q <= '{instr: imem_instr, pc4: pc_plus4, valid: 1'b1};
      end
    end
  end

  assign pc_out         = pc_q;
  assign ifid_instr     = ifid_q.instr;
  assign ifid_pc4       = ifid_q.pc4;
  assign ifid_valid     = ifid_q.valid;
  assign redirect       = redirect_q;
  assign misalign       = misalign_q;
  assign redirect_count = count_q;

endmodule
